// File: rtl/sccb_slave.sv
// SCCB write target: decodes ID/sub-address/data writes into a 256x8 register file.
// Optional SCCB_ACK_EN drives sda_oe low-pull during each ninth-bit ACK slot.
module sccb_slave #(
  parameter logic [7:0] DEV_ID   = 8'h42,
  parameter int         SYNC_LEN = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sccb_clk,
  input  logic       sccb_dat,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE, ID, SUB, DATA, DONE, IGNORE
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_LEN-1:0] clk_sync;
  logic [SYNC_LEN-1:0] dat_sync;
  logic clk_s, dat_s;
  logic clk_d, dat_d;
  logic rise, start, stop;

  logic [3:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] sh_q, sh_n;
  logic [7:0] sub_q, sub_n;
  logic [7:0] byte_in;
  logic       err_n;
  logic       commit;

  logic [7:0] regs [256];

  // Idle bus is high; reset the chain high so release causes no false START.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
      dat_d    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_LEN-2:0], sccb_clk};
      dat_sync <= {dat_sync[SYNC_LEN-2:0], sccb_dat};
      clk_d    <= clk_s;
      dat_d    <= dat_s;
    end
  end

  assign clk_s = clk_sync[SYNC_LEN-1];
  assign dat_s = dat_sync[SYNC_LEN-1];

  assign rise  = clk_s & ~clk_d;
  assign start = clk_s & clk_d & dat_d & ~dat_s;
  assign stop  = clk_s & clk_d & ~dat_d & dat_s;

  assign byte_in = {sh_q[6:0], dat_s};

  always_comb begin
    state_n   = state_q;
    bit_cnt_n = bit_cnt_q;
    sh_n      = sh_q;
    sub_n     = sub_q;
    err_n     = 1'b0;
    commit    = 1'b0;
    if (stop) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      // The STOP condition's own clock rise lands as one phantom bit.
      err_n = (state_q == ID) ||
              ((state_q == DATA) && (bit_cnt_q > 4'd1));
    end else if (start) begin
      state_n   = ID;
      bit_cnt_n = 4'd0;
      err_n     = (state_q == ID) || (state_q == SUB) ||
                  (state_q == DATA);
    end else if (rise) begin
      unique case (state_q)
        ID, SUB, DATA: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_n = 4'd0;
            unique case (state_q)
              ID:      state_n = SUB;
              SUB:     state_n = DATA;
              default: begin
                state_n = DONE;
                commit  = 1'b1;
              end
            endcase
          end else begin
            sh_n      = byte_in;
            bit_cnt_n = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if ((state_q == ID) && (byte_in != DEV_ID)) begin
                state_n   = IGNORE;
                bit_cnt_n = 4'd0;
              end
              if (state_q == SUB) sub_n = byte_in;
            end
          end
        end
        default: ;
      endcase
    end else if (state_q == IDLE) begin
      bit_cnt_n = 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      sh_q      <= 8'h00;
      sub_q     <= 8'h00;
      err       <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      state_q   <= state_n;
      bit_cnt_q <= bit_cnt_n;
      sh_q      <= sh_n;
      sub_q     <= sub_n;
      err       <= err_n;
      wr_en     <= commit;
      if (commit) begin
        wr_addr <= sub_q;
        wr_data <= sh_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else if (commit) begin
      regs[sub_q] <= sh_q;
    end
  end

  assign rd_data = regs[rd_addr];
  assign busy    = (state_q != IDLE);

`ifdef SCCB_ACK_EN
  logic fall;
  logic ack_q;

  assign fall = ~clk_s & clk_d;

  always_ff @(posedge clock) begin
    if (reset || start || stop) begin
      ack_q <= 1'b0;
    end else if (fall) begin
      ack_q <= ((state_q == ID) || (state_q == SUB) ||
                (state_q == DATA)) && (bit_cnt_q == 4'd8);
    end
  end

  assign sda_oe = ack_q;
`else
  assign sda_oe = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-banged SCCB master plus pulse counters.
// Build with SCCB_ACK_EN defined to also expect the three ACK slots.
module tb_sccb_slave;

  localparam int Q = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sccb_clk = 1'b1;
  logic       sccb_dat = 1'b1;
  logic       sda_oe;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int ack_cnt = 0;
  logic oe_prev = 1'b0;

  int w0, e0, a0;

  sccb_slave dut (
    .clock    (clock),
    .reset    (reset),
    .sccb_clk (sccb_clk),
    .sccb_dat (sccb_dat),
    .sda_oe   (sda_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .err      (err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (sda_oe && !oe_prev) ack_cnt <= ack_cnt + 1;
    oe_prev <= sda_oe;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clock);
  endtask

  task automatic bus_start();
    sccb_dat = 1'b1;
    wq();
    sccb_clk = 1'b1;
    wq();
    sccb_dat = 1'b0;
    wq();
    sccb_clk = 1'b0;
    wq();
  endtask

  task automatic bus_stop();
    sccb_dat = 1'b0;
    wq();
    sccb_clk = 1'b1;
    wq();
    sccb_dat = 1'b1;
    wq();
    wq();
  endtask

  task automatic send_bit(input logic b);
    sccb_dat = b;
    wq();
    sccb_clk = 1'b1;
    wq();
    sccb_clk = 1'b0;
    wq();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[7-i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
    send_bit(1'b1);
  endtask

  task automatic mark();
    @(negedge clock);
    w0 = wr_cnt;
    e0 = err_cnt;
    a0 = ack_cnt;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                    input string tag);
    rd_addr = a;
    @(negedge clock);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int ack_exp;
`ifdef SCCB_ACK_EN
    ack_exp = 3;
`else
    ack_exp = 0;
`endif
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_err", err, 0);
    check("rst_oe", sda_oe, 0);
    check("rst_waddr", wr_addr, 0);
    check("rst_wdata", wr_data, 0);
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a);
      #1;
      check("rst_sweep", rd_data, 0);
    end

    // full write 42/55/A5
    mark();
    bus_start();
    check("w1_busy_start", busy, 1);
    send_byte(8'h42);
    send_byte(8'h55);
    send_byte(8'hA5);
    check("w1_busy_pre_stop", busy, 1);
    bus_stop();
    check("w1_busy_stop", busy, 0);
    check("w1_wr_cnt", wr_cnt - w0, 1);
    check("w1_err_cnt", err_cnt - e0, 0);
    check("w1_ack_cnt", ack_cnt - a0, ack_exp);
    check("w1_waddr", wr_addr, 8'h55);
    check("w1_wdata", wr_data, 8'hA5);
    check("w1_oe_idle", sda_oe, 0);
    rd(8'h55, 8'hA5, "w1_rd55");

    // foreign ID 44
    mark();
    bus_start();
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h11);
    check("id_busy", busy, 1);
    bus_stop();
    check("id_busy_stop", busy, 0);
    check("id_wr_cnt", wr_cnt - w0, 0);
    check("id_err_cnt", err_cnt - e0, 0);
    check("id_ack_cnt", ack_cnt - a0, 0);
    rd(8'h55, 8'hA5, "id_rd55");

    // two-phase write 42/10
    mark();
    bus_start();
    send_byte(8'h42);
    send_byte(8'h10);
    bus_stop();
    check("p2_wr_cnt", wr_cnt - w0, 0);
    check("p2_err_cnt", err_cnt - e0, 0);
    check("p2_waddr", wr_addr, 8'h55);

    // stop after four data bits
    mark();
    bus_start();
    send_byte(8'h42);
    send_byte(8'h10);
    send_bits(8'hF0, 4);
    bus_stop();
    check("pd_wr_cnt", wr_cnt - w0, 0);
    check("pd_err_cnt", err_cnt - e0, 1);
    check("pd_busy", busy, 0);
    rd(8'h10, 8'h00, "pd_rd10");

    // repeated start after five sub bits
    mark();
    bus_start();
    send_byte(8'h42);
    send_bits(8'hF8, 5);
    bus_start();
    check("rs_busy", busy, 1);
    send_byte(8'h42);
    send_byte(8'h20);
    send_byte(8'h3C);
    bus_stop();
    check("rs_err_cnt", err_cnt - e0, 1);
    check("rs_wr_cnt", wr_cnt - w0, 1);
    check("rs_waddr", wr_addr, 8'h20);
    check("rs_wdata", wr_data, 8'h3C);
    rd(8'h20, 8'h3C, "rs_rd20");
    rd(8'h55, 8'hA5, "rs_rd55");

    // reset mid-transaction
    mark();
    bus_start();
    send_byte(8'h42);
    send_bits(8'h33, 3);
    reset = 1'b1;
    sccb_clk = 1'b1;
    sccb_dat = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("mr_busy", busy, 0);
    check("mr_err_cnt", err_cnt - e0, 0);
    check("mr_waddr", wr_addr, 8'h00);
    rd(8'h55, 8'h00, "mr_rd55");
    rd(8'h20, 8'h00, "mr_rd20");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
